// File: rtl/lsu_rmw_pkg.sv
// Shared size codes, FSM encodings and alignment helper for the load/store unit.
// Pure definitions, no timing; imported by every lsu_rmw file.
package lsu_rmw_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_ACCESS = 2'b01;
  localparam logic [1:0] ST_WRITE  = 2'b10;
  localparam logic [1:0] ST_DONE   = 2'b11;

  // Size code 11 behaves as a word access everywhere.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] ofs);
    if (size[1])
      return (ofs != 2'b00);
    else if (size == SZ_H)
      return ofs[0];
    else
      return 1'b0;
  endfunction

endpackage

// File: rtl/lsu_rmw_lane.sv
// Lane steering: extracts/extends a sub-word load and merges a sub-word store into a word.
// Purely combinational (zero latency), no flow control.
module lsu_rmw_lane
  import lsu_rmw_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  ofs_i,
  input  logic [1:0]  size_i,
  input  logic        sgn_i,
  input  logic [31:0] din_i,
  output logic [31:0] load_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v   = word_i[7:0];
    half_v   = ofs_i[1] ? word_i[31:16] : word_i[15:0];
    load_o   = word_i;
    merged_o = din_i;
    case (ofs_i)
      2'b00: byte_v = word_i[7:0];
      2'b01: byte_v = word_i[15:8];
      2'b10: byte_v = word_i[23:16];
      default: byte_v = word_i[31:24];
    endcase
    if (size_i == SZ_B) begin
      load_o = {{24{sgn_i & byte_v[7]}}, byte_v};
      case (ofs_i)
        2'b00: merged_o = {word_i[31:8], din_i[7:0]};
        2'b01: merged_o = {word_i[31:16], din_i[7:0], word_i[7:0]};
        2'b10: merged_o = {word_i[31:24], din_i[7:0], word_i[15:0]};
        default: merged_o = {din_i[7:0], word_i[23:0]};
      endcase
    end else if (size_i == SZ_H) begin
      load_o   = {{16{sgn_i & half_v[15]}}, half_v};
      merged_o = ofs_i[1] ? {din_i[15:0], word_i[15:0]} : {word_i[31:16], din_i[15:0]};
    end
  end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store initiator: one request at a time, read-modify-write for sub-word stores.
// Latency 1 (misaligned) / 2 (load, word store) / 3 (sub-word store); req ignored unless ready.
module lsu_rmw
  import lsu_rmw_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  input  logic [31:0] pc,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [31:0] dout,
  output logic [31:0] memAdr,
  output logic        memWrite,
  output logic [31:0] wdata,
  output logic [31:0] wPc,
  input  logic [31:0] memOut
);

  logic [1:0]  state_q, state_d;
  logic        we_q, sgn_q, err_q;
  logic [1:0]  size_q, ofs_q;
  logic [31:0] din_q, dout_q, adr_q, wdata_q, pc_q;
  logic [31:0] load_val, merged_val;
  logic        accept, req_mis, sub_store;

  assign accept    = (state_q == ST_IDLE) && req;
  assign req_mis   = misaligned(size, addr[1:0]);
  assign sub_store = we_q && !size_q[1];

  lsu_rmw_lane u_lane (
    .word_i   (memOut),
    .ofs_i    (ofs_q),
    .size_i   (size_q),
    .sgn_i    (sgn_q),
    .din_i    (din_q),
    .load_o   (load_val),
    .merged_o (merged_val)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (req) state_d = req_mis ? ST_DONE : ST_ACCESS;
      ST_ACCESS: state_d = sub_store ? ST_WRITE : ST_DONE;
      ST_WRITE:  state_d = ST_DONE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SZ_B;
      ofs_q   <= 2'b00;
      din_q   <= '0;
      dout_q  <= '0;
      adr_q   <= '0;
      wdata_q <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q   <= we;
        sgn_q  <= sgn;
        size_q <= size;
        ofs_q  <= addr[1:0];
        din_q  <= din;
        pc_q   <= pc;
        err_q  <= req_mis;
        // A misaligned request never reaches the memory port, so its address/data stay put.
        if (!req_mis) begin
          adr_q   <= {addr[31:2], 2'b00};
          wdata_q <= din;
        end
      end
      if (state_q == ST_ACCESS) begin
        if (!we_q)
          dout_q <= load_val;
        else if (sub_store)
          wdata_q <= merged_val;
      end
    end
  end

  assign ready    = (state_q == ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign err      = done && err_q;
  assign dout     = dout_q;
  assign memAdr   = adr_q;
  assign wdata    = wdata_q;
  assign wPc      = pc_q;
  // Gated by reset so an aborted RMW can never commit on the reset edge.
  assign memWrite = !reset &&
                    (((state_q == ST_ACCESS) && we_q && size_q[1]) || (state_q == ST_WRITE));

endmodule

// File: tb/tb_lsu_rmw.sv
// Directed + randomized check of lsu_rmw against a word-array memory and arithmetic reference model.
module tb_lsu_rmw;

  logic        clk = 1'b0;
  logic        reset, req, we, sgn;
  logic [1:0]  size;
  logic [31:0] addr, din, pc;
  logic        ready, done, err, memWrite;
  logic [31:0] dout, memAdr, wdata, wPc, memOut;

  bit   [31:0] tb_mem  [64];
  bit   [31:0] ref_mem [64];
  logic [31:0] ref_dout;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  lsu_rmw dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .sgn(sgn),
    .addr(addr), .din(din), .pc(pc), .ready(ready), .done(done), .err(err),
    .dout(dout), .memAdr(memAdr), .memWrite(memWrite), .wdata(wdata),
    .wPc(wPc), .memOut(memOut)
  );

  assign memOut = tb_mem[memAdr[7:2]];
  always @(posedge clk) if (memWrite) tb_mem[memAdr[7:2]] <= wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] ofs,
                                           input logic [1:0] sz, input bit sg);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (w >> (8 * ofs)) & 32'hFF;
      if (sg && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (w >> (16 * ofs[1])) & 32'hFFFF;
      if (sg && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [1:0] ofs,
                                            input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] mask;
    int          sh;
    if (sz == 2'd0) begin
      sh   = 8 * ofs;
      mask = 32'hFF << sh;
    end else begin
      sh   = 16 * ofs[1];
      mask = 32'hFFFF << sh;
    end
    return (w & ~mask) | ((d << sh) & mask);
  endfunction

  task automatic do_op(input bit w, input logic [1:0] sz, input bit sg, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] p, input bit noise);
    int lat, nwr, exp_lat, exp_wr;
    bit seen_done, mis;
    int idx;
    idx = int'(a[7:2]);
    mis = (sz == 2'd1 && a[0]) || (sz[1] && a[1:0] != 2'b00);
    @(negedge clk);
    chk("ready_idle", 32'(ready), 32'd1);
    req = 1'b1; we = w; size = sz; sgn = sg; addr = a; din = d; pc = p;
    @(posedge clk); #1;
    req = 1'b0; we = 1'($urandom); addr = $urandom; din = $urandom; pc = $urandom;
    lat = 0; nwr = 0; seen_done = 1'b0;
    while (!seen_done && lat < 8) begin
      @(negedge clk);
      lat++;
      if (memWrite) begin
        nwr++;
        chk("wr_adr", memAdr, {a[31:2], 2'b00});
      end
      chk("wpc", wPc, p);
      if (done) seen_done = 1'b1;
      if (noise) begin
        req = 1'b1; we = 1'($urandom); size = 2'($urandom); addr = $urandom_range(0, 255);
        din = $urandom; pc = $urandom;
      end
    end
    if (mis) begin
      exp_lat = 1; exp_wr = 0;
    end else if (!w) begin
      exp_lat = 2; exp_wr = 0;
      ref_dout = ref_load(ref_mem[idx], a[1:0], sz, sg);
    end else if (sz[1]) begin
      exp_lat = 2; exp_wr = 1;
      ref_mem[idx] = d;
    end else begin
      exp_lat = 3; exp_wr = 1;
      ref_mem[idx] = ref_store(ref_mem[idx], a[1:0], sz, d);
    end
    chk("done_seen", 32'(seen_done), 32'd1);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("err", 32'(err), 32'(mis));
    chk("dout", dout, ref_dout);
    chk("writes", 32'(nwr), 32'(exp_wr));
    chk("mem_word", tb_mem[idx], ref_mem[idx]);
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; sgn = 1'b0;
    addr = '0; din = '0; pc = '0; ref_dout = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mw", 32'(memWrite), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_dout", dout, 32'd0);
    chk("rst_adr", memAdr, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_wpc", wPc, 32'd0);

    // Word store / load
    do_op(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0000_1000, 1'b0);
    do_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0000_1004, 1'b0);
    chk("tp_lw", dout, 32'hDEAD_BEEF);

    // Byte RMW and byte loads
    do_op(1'b1, 2'b10, 1'b0, 32'h20, 32'h1122_3344, 32'h0000_1008, 1'b0);
    do_op(1'b1, 2'b00, 1'b0, 32'h22, 32'h0000_00AA, 32'h0000_100C, 1'b1);
    chk("tp_sb", tb_mem[8], 32'h11AA_3344);
    do_op(1'b0, 2'b00, 1'b1, 32'h22, 32'h0, 32'h0000_1010, 1'b1);
    chk("tp_lb", dout, 32'hFFFF_FFAA);
    do_op(1'b0, 2'b00, 1'b0, 32'h22, 32'h0, 32'h0000_1014, 1'b0);
    chk("tp_lbu", dout, 32'h0000_00AA);

    // Half RMW and half loads
    do_op(1'b1, 2'b01, 1'b0, 32'h26, 32'h0000_8001, 32'h0000_1018, 1'b0);
    chk("tp_sh", tb_mem[9], 32'h8001_0000);
    do_op(1'b0, 2'b01, 1'b1, 32'h26, 32'h0, 32'h0000_101C, 1'b1);
    chk("tp_lh", dout, 32'hFFFF_8001);
    do_op(1'b0, 2'b01, 1'b0, 32'h26, 32'h0, 32'h0000_1020, 1'b0);
    chk("tp_lhu", dout, 32'h0000_8001);

    // Misaligned: no access, dout held
    do_op(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 32'h0000_1024, 1'b0);
    do_op(1'b1, 2'b01, 1'b0, 32'h31, 32'h0000_FFFF, 32'h0000_1028, 1'b1);
    chk("tp_mis_dout", dout, 32'h0000_8001);

    // Reset in the middle of an RMW
    do_op(1'b1, 2'b10, 1'b0, 32'h40, 32'h5555_5555, 32'h0000_102C, 1'b0);
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b00; sgn = 1'b0; addr = 32'h40; din = 32'hAA; pc = 32'h2222;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    chk("rmw_access_mw", 32'(memWrite), 32'd0);
    @(negedge clk);
    chk("rmw_write_mw", 32'(memWrite), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_gate_mw", 32'(memWrite), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    chk("rmw_rst_done", 32'(done), 32'd0);
    chk("rmw_rst_ready", 32'(ready), 32'd1);
    chk("rmw_rst_dout", dout, 32'd0);
    chk("rmw_rst_adr", memAdr, 32'd0);
    chk("rmw_rst_wdata", wdata, 32'd0);
    chk("rmw_rst_wpc", wPc, 32'd0);
    chk("rmw_rst_mem", tb_mem[16], 32'h5555_5555);
    ref_dout = '0;
    @(negedge clk);
    chk("rmw_rst_nodone", 32'(done), 32'd0);

    // Randomized traffic over a 64-word window
    for (int i = 0; i < 150; i++) begin
      do_op(1'($urandom), 2'($urandom), 1'($urandom), 32'($urandom_range(0, 255)),
            $urandom, $urandom, 1'($urandom));
    end
    @(negedge clk);
    req = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
